conv_window_compactor: RTL and testbench

Parametrised stream compactor between a convolution/pooling PE array and the next layer's buffer. It receives one PE result per input-pixel position in raster order and discards the positions where the sliding window was incomplete or skipped by the stride. Kept results go into an internal FIFO, and downstream reads them over a valid/ready handshake. Feature-map size, kernel size, stride and lane count are set by parameters or runtime configuration, so one block serves every layer.

---
 rtl/conv_window_compactor.sv | 194 +++++++++++++++++++
 tb/tb_conv_window_compactor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_compactor.sv
// Stream compactor: keeps the PE results at valid, stride-aligned window positions
// of a raster-ordered feature map and buffers them in a first-word-fall-through FIFO.
module conv_window_compactor #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned LANES    = 1,
    parameter int unsigned MAX_FMAP = 32,
    parameter int unsigned DEPTH    = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic [$clog2(MAX_FMAP):0]     fmap_size,
    input  logic [2:0]                    kernel_size,
    input  logic [1:0]                    stride,
    input  logic [LANES*DWIDTH-1:0]       din,
    input  logic                          din_valid,
    output logic [LANES*DWIDTH-1:0]       dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          cfg_error
);
    localparam int unsigned CW = $clog2(MAX_FMAP);
    localparam int unsigned NW = CW + 1;
    localparam int unsigned DW = LANES * DWIDTH;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [1:0]    r_cph;
    logic [1:0]    r_rph;
    logic [NW-1:0] r_n;
    logic [2:0]    r_k;
    logic [1:0]    r_s;
    logic          r_bad;
    logic          r_keep_q;
    logic [DW-1:0] r_data_q;
    logic          r_frame_done;
    logic          r_cfg_error;
    logic          r_overflow;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_start;
    logic [1:0]    w_s_in;
    logic          w_bad_in;
    logic [NW-1:0] w_n;
    logic [2:0]    w_k;
    logic [1:0]    w_s;
    logic          w_bad;
    logic [NW-1:0] w_nm1;
    logic [NW-1:0] w_km1;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_col_in;
    logic          w_row_in;
    logic          w_keep;
    logic          w_full;
    logic          w_rd;
    logic          w_wr;

    // At row=col=0 the live config applies, so the first position of a frame uses it too
    assign w_start  = (r_row == '0) && (r_col == '0);
    assign w_s_in   = (stride == 2'd0) ? 2'd1 : stride;
    assign w_bad_in = (NW'(kernel_size) > fmap_size) || (kernel_size == 3'd0) ||
                      (fmap_size < NW'(2));
    assign w_n      = w_start ? fmap_size : r_n;
    assign w_k      = w_start ? kernel_size : r_k;
    assign w_s      = w_start ? w_s_in : r_s;
    assign w_bad    = w_start ? w_bad_in : r_bad;

    assign w_nm1      = w_n - NW'(1);
    assign w_km1      = NW'(w_k) - NW'(1);
    assign w_col_last = (NW'(r_col) == w_nm1);
    assign w_row_last = (NW'(r_row) == w_nm1);
    assign w_col_in   = (NW'(r_col) >= w_km1);
    assign w_row_in   = (NW'(r_row) >= w_km1);
    assign w_keep     = din_valid && !w_bad && w_col_in && w_row_in &&
                        (r_cph == 2'd0) && (r_rph == 2'd0);

    assign w_full = (r_count == (AW+1)'(DEPTH));
    assign w_rd   = (r_count != '0) && dout_ready;
    assign w_wr   = r_keep_q && (!w_full || w_rd);

    assign dout       = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign dout_valid = (r_count != '0);
    assign fifo_count = r_count;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign cfg_error  = r_cfg_error;

    // Raster position, stride phases, config latch and keep pipeline stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_cph        <= '0;
            r_rph        <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_s          <= 2'd1;
            r_bad        <= 1'b0;
            r_keep_q     <= 1'b0;
            r_data_q     <= '0;
            r_frame_done <= 1'b0;
            r_cfg_error  <= 1'b0;
        end else if (clear) begin
            r_row        <= '0;
            r_col        <= '0;
            r_cph        <= '0;
            r_rph        <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_s          <= 2'd1;
            r_bad        <= 1'b0;
            r_keep_q     <= 1'b0;
            r_data_q     <= '0;
            r_frame_done <= 1'b0;
            r_cfg_error  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_keep_q     <= w_keep;
            if (w_keep) begin
                r_data_q <= din;
            end
            if (din_valid) begin
                if (w_start) begin
                    r_n         <= fmap_size;
                    r_k         <= kernel_size;
                    r_s         <= w_s_in;
                    r_bad       <= w_bad_in;
                    r_cfg_error <= r_cfg_error | w_bad_in;
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_cph <= '0;
                    if (w_row_last) begin
                        r_row        <= '0;
                        r_rph        <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row <= r_row + CW'(1);
                        if (w_row_in) begin
                            r_rph <= (r_rph == w_s - 2'd1) ? 2'd0 : r_rph + 2'd1;
                        end
                    end
                end else begin
                    r_col <= r_col + CW'(1);
                    if (w_col_in) begin
                        r_cph <= (r_cph == w_s - 2'd1) ? 2'd0 : r_cph + 2'd1;
                    end
                end
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            if (r_keep_q && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy gates what is visible on dout
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= r_data_q;
        end
    end

endmodule

// File: tb/tb_conv_window_compactor.sv
// Directed bench for conv_window_compactor: raster frames with known kept positions,
// FIFO full/empty behaviour, reset mid-frame and illegal configuration.
module tb_conv_window_compactor;
    localparam int unsigned DWIDTH   = 16;
    localparam int unsigned LANES    = 2;
    localparam int unsigned MAX_FMAP = 32;
    localparam int unsigned DEPTH    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [5:0]  fmap_size;
    logic [2:0]  kernel_size;
    logic [1:0]  stride;
    logic [31:0] din;
    logic        din_valid;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [4:0]  fifo_count;
    logic        frame_done;
    logic        overflow;
    logic        cfg_error;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          n_done = 0;
    int          max_cnt = 0;
    int          t12 = 0;
    bit          rand_ready = 1'b0;
    logic [31:0] got_q [$];
    int          exp_q [$];

    conv_window_compactor #(
        .DWIDTH  (DWIDTH),
        .LANES   (LANES),
        .MAX_FMAP(MAX_FMAP),
        .DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .fmap_size  (fmap_size),
        .kernel_size(kernel_size),
        .stride     (stride),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_count (fifo_count),
        .frame_done (frame_done),
        .overflow   (overflow),
        .cfg_error  (cfg_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Collect handshaken words and track pulses/occupancy, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && dout_valid && dout_ready) begin
            got_q.push_back(dout);
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (frame_done) n_done++;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int v, input bit vld);
        @(posedge clk);
        #1;
        din       = {16'(v + 100), 16'(v)};
        din_valid = vld;
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(0, 1'b0);
    endtask

    task automatic set_cfg(input int n, input int k, input int s);
        fmap_size   = 6'(n);
        kernel_size = 3'(k);
        stride      = 2'(s);
    endtask

    task automatic do_clear();
        @(posedge clk);
        #1;
        clear     = 1'b1;
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        got_q.delete();
        n_done    = 0;
        max_cnt   = 0;
        first_cyc = -1;
    endtask

    task automatic run_frame(input int n, input bit perturb);
        for (int i = 0; i < n * n; i++) begin
            send(i, 1'b1);
            if (i == 12) t12 = cyc;
            if (perturb && i == 1) set_cfg(20, 5, 1);
        end
        send(0, 1'b0);
    endtask

    task automatic wait_out(input int want, input int budget);
        int b = 0;
        while (got_q.size() < want && b < budget) begin
            send(0, 1'b0);
            b++;
        end
        idle(4);
    endtask

    task automatic build_exp(input int n, input int k, input int s);
        exp_q.delete();
        for (int r = k - 1; r < n; r += s)
            for (int c = k - 1; c < n; c += s)
                exp_q.push_back(r * n + c);
    endtask

    function automatic int lane(input int idx, input int ln);
        logic [31:0] w;
        if (idx >= got_q.size()) return -1;
        w = got_q[idx];
        return (ln == 0) ? int'(w[15:0]) : int'(w[31:16]);
    endfunction

    task automatic cmp_seq(input string tag);
        int bad = 0;
        int lim;
        lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < lim; i++) begin
            if (lane(i, 0) != (exp_q[i] & 16'hffff) || lane(i, 1) != ((exp_q[i] + 100) & 16'hffff))
                bad++;
        end
        check_eq({tag, "_order"}, bad, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        set_cfg(30, 3, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_dout_valid", dout_valid, 0);
        check_eq("rst_dout", dout, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_cfg_error", cfg_error, 0);
        dout_ready = 1'b1;
        idle(3);
        check_eq("empty_read_count", fifo_count, 0);
        check_eq("empty_read_valid", dout_valid, 0);

        // n=30 k=3 s=1
        do_clear();
        set_cfg(30, 3, 1);
        run_frame(30, 1'b0);
        wait_out(784, 200);
        build_exp(30, 3, 1);
        cmp_seq("conv30");
        check_eq("conv30_first", lane(0, 0), 62);
        check_eq("conv30_last", lane(783, 0), 899);
        check_eq("conv30_done", n_done, 1);
        check_eq("conv30_ovf", overflow, 0);

        // n=28 k=2 s=2 pooling, config perturbed mid-frame
        do_clear();
        set_cfg(28, 2, 2);
        run_frame(28, 1'b1);
        wait_out(196, 200);
        build_exp(28, 2, 2);
        cmp_seq("pool28");
        check_eq("pool28_o0", lane(0, 0), 29);
        check_eq("pool28_o1", lane(1, 0), 31);
        check_eq("pool28_row2", lane(14, 0), 85);
        check_eq("pool28_row3", lane(28, 0), 141);
        check_eq("pool28_done", n_done, 1);

        // n=5 k=3 s=1, two lanes, latency
        do_clear();
        set_cfg(5, 3, 1);
        run_frame(5, 1'b0);
        wait_out(9, 50);
        exp_q = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
        cmp_seq("lanes5");
        check_eq("lanes5_lane1", lane(0, 1), 112);
        check_eq("lanes5_latency", first_cyc - t12, 2);

        // FIFO full: n=14 with consumer stalled
        do_clear();
        set_cfg(14, 3, 1);
        dout_ready = 1'b0;
        run_frame(14, 1'b0);
        idle(3);
        check_eq("full_count", fifo_count, 16);
        check_eq("full_ovf", overflow, 1);
        check_eq("full_valid", dout_valid, 1);
        check_eq("full_head", dout[15:0], 30);
        check_eq("full_done", n_done, 1);
        dout_ready = 1'b1;
        wait_out(16, 100);
        build_exp(14, 3, 1);
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        cmp_seq("drain14");
        check_eq("drain14_row3", lane(12, 0), 44);
        check_eq("drain14_empty", fifo_count, 0);

        // Random consumer, throttled producer
        do_clear();
        set_cfg(12, 3, 1);
        rand_ready = 1'b1;
        begin
            int i = 0;
            int guard = 0;
            while (i < 144 && guard < 5000) begin
                guard++;
                if (fifo_count <= 5'd13) begin
                    send(i, 1'b1);
                    i++;
                end else begin
                    send(0, 1'b0);
                end
            end
        end
        send(0, 1'b0);
        wait_out(100, 2000);
        rand_ready = 1'b0;
        dout_ready = 1'b1;
        idle(4);
        build_exp(12, 3, 1);
        cmp_seq("rand12");
        check_eq("rand12_max_le_depth", (max_cnt <= 16) ? 1 : 0, 1);
        check_eq("rand12_ovf", overflow, 0);
        check_eq("rand12_done", n_done, 1);

        // stride 0 behaves as 1
        do_clear();
        set_cfg(6, 2, 0);
        run_frame(6, 1'b0);
        wait_out(25, 100);
        build_exp(6, 2, 1);
        cmp_seq("s0");
        check_eq("s0_first", lane(0, 0), 7);

        // Reset mid-frame, then a fresh frame
        do_clear();
        set_cfg(30, 3, 1);
        dout_ready = 1'b0;
        for (int i = 0; i < 200; i++) send(i, 1'b1);
        @(posedge clk);
        #1;
        check_eq("mid_pre_ovf", overflow, 1);
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        check_eq("mid_rst_count", fifo_count, 0);
        check_eq("mid_rst_valid", dout_valid, 0);
        check_eq("mid_rst_ovf", overflow, 0);
        check_eq("mid_rst_dout", dout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        got_q.delete();
        n_done = 0;
        first_cyc = -1;
        dout_ready = 1'b1;
        run_frame(30, 1'b0);
        wait_out(784, 200);
        build_exp(30, 3, 1);
        cmp_seq("after_rst");
        check_eq("after_rst_first", lane(0, 0), 62);
        check_eq("after_rst_done", n_done, 1);

        // Illegal config k > n
        do_clear();
        set_cfg(5, 7, 1);
        run_frame(5, 1'b0);
        idle(5);
        check_eq("cfg_err_flag", cfg_error, 1);
        check_eq("cfg_err_outputs", got_q.size(), 0);
        check_eq("cfg_err_count", fifo_count, 0);
        check_eq("cfg_err_done", n_done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
